// File: rtl/tmds_encoder_pipe.sv
// tmds_encoder_pipe: two-stage TMDS encoder for NUM_CH independent channels.
// Stage 1 applies transition minimisation (XOR/XNOR chain) and stage 2
// applies DC balancing with a per-channel running disparity, or emits the
// control token during blanking.
// Streaming contract: no valid/ready handshake. Every cycle is a transfer;
// de_in qualifies the cycle as video (1) or control (0). de_out tags the
// symbols on tmds_out two cycles later.
module tmds_encoder_pipe #(
  parameter int NUM_CH = 3
) (
  input  logic                 clk_in,
  input  logic                 rst_in,
  input  logic                 de_in,
  input  logic [8*NUM_CH-1:0]  data_in,
  input  logic [2*NUM_CH-1:0]  ctrl_in,
  output logic [10*NUM_CH-1:0] tmds_out,
  output logic                 de_out
);

  localparam logic [9:0] TOK_00 = 10'b1101010100;
  localparam logic [9:0] TOK_01 = 10'b0010101011;
  localparam logic [9:0] TOK_10 = 10'b0101010100;
  localparam logic [9:0] TOK_11 = 10'b1010101011;

  logic r_de1;
  logic r_de2;

  // Data-enable pipeline shared by all channels
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      r_de1 <= 1'b0;
      r_de2 <= 1'b0;
    end else begin
      r_de1 <= de_in;
      r_de2 <= r_de1;
    end
  end

  assign de_out = r_de2;

  for (genvar ch = 0; ch < NUM_CH; ch++) begin : g_ch
    logic [7:0]        w_d;
    logic [8:0]        w_qm;
    logic [8:0]        r_qm;
    logic [1:0]        r_ctrl1;
    logic [3:0]        w_n1;
    logic [3:0]        w_n0;
    logic signed [4:0] w_diff;
    logic signed [4:0] w_cnt_nxt;
    logic [9:0]        w_sym;
    logic signed [4:0] r_cnt;
    logic [9:0]        r_tmds;

    assign w_d = data_in[8*ch +: 8];

    // Transition minimisation: pick XOR or XNOR chain from the byte's ones count
    always_comb begin
      logic [3:0] n1d;
      logic       use_xnor;
      logic [8:0] qm;
      n1d = 4'd0;
      for (int k = 0; k < 8; k++) n1d = n1d + {3'd0, w_d[k]};
      use_xnor = (n1d > 4'd4) || ((n1d == 4'd4) && !w_d[0]);
      qm = 9'd0;
      qm[0] = w_d[0];
      for (int k = 1; k < 8; k++) begin
        qm[k] = use_xnor ? ~(qm[k-1] ^ w_d[k]) : (qm[k-1] ^ w_d[k]);
      end
      qm[8] = ~use_xnor;
      w_qm = qm;
    end

    // Stage-1 register: intermediate word and control bits
    always_ff @(posedge clk_in) begin
      if (rst_in) begin
        r_qm    <= 9'd0;
        r_ctrl1 <= 2'd0;
      end else begin
        r_qm    <= w_qm;
        r_ctrl1 <= ctrl_in[2*ch +: 2];
      end
    end

    // Ones/zeros balance of the intermediate word as a signed difference
    always_comb begin
      logic [3:0] n1;
      n1 = 4'd0;
      for (int k = 0; k < 8; k++) n1 = n1 + {3'd0, r_qm[k]};
      w_n1   = n1;
      w_n0   = 4'd8 - n1;
      w_diff = $signed({1'b0, w_n1}) - $signed({1'b0, w_n0});
    end

    // DC balancing and control-token selection; cnt cleared in blanking
    always_comb begin
      w_sym     = TOK_00;
      w_cnt_nxt = 5'sd0;
      if (!r_de1) begin
        case (r_ctrl1)
          2'b00:   w_sym = TOK_00;
          2'b01:   w_sym = TOK_01;
          2'b10:   w_sym = TOK_10;
          default: w_sym = TOK_11;
        endcase
        w_cnt_nxt = 5'sd0;
      end else if ((r_cnt == 5'sd0) || (w_n1 == 4'd4)) begin
        w_sym     = {~r_qm[8], r_qm[8], r_qm[8] ? r_qm[7:0] : ~r_qm[7:0]};
        w_cnt_nxt = r_qm[8] ? (r_cnt + w_diff) : (r_cnt - w_diff);
      end else if (((r_cnt > 5'sd0) && (w_n1 > 4'd4)) ||
                   ((r_cnt < 5'sd0) && (w_n1 < 4'd4))) begin
        w_sym     = {1'b1, r_qm[8], ~r_qm[7:0]};
        w_cnt_nxt = r_cnt + (r_qm[8] ? 5'sd2 : 5'sd0) - w_diff;
      end else begin
        w_sym     = {1'b0, r_qm[8], r_qm[7:0]};
        w_cnt_nxt = r_cnt - (r_qm[8] ? 5'sd0 : 5'sd2) + w_diff;
      end
    end

    // Stage-2 register: output symbol and running disparity
    always_ff @(posedge clk_in) begin
      if (rst_in) begin
        r_tmds <= 10'd0;
        r_cnt  <= 5'sd0;
      end else begin
        r_tmds <= w_sym;
        r_cnt  <= w_cnt_nxt;
      end
    end

    assign tmds_out[10*ch +: 10] = r_tmds;
  end

endmodule

// File: tb/tb_tmds_encoder_pipe.sv
// tb_tmds_encoder_pipe: directed checks of the 3-channel TMDS encoder pipe.
module tb_tmds_encoder_pipe;

  logic        clk_in;
  logic        rst_in;
  logic        de_in;
  logic [23:0] data_in;
  logic [5:0]  ctrl_in;
  logic [29:0] tmds_out;
  logic        de_out;

  int checks;
  int errors;

  tmds_encoder_pipe #(.NUM_CH(3)) dut (
    .clk_in   (clk_in),
    .rst_in   (rst_in),
    .de_in    (de_in),
    .data_in  (data_in),
    .ctrl_in  (ctrl_in),
    .tmds_out (tmds_out),
    .de_out   (de_out)
  );

  // Clock
  initial clk_in = 1'b0;
  always #5 clk_in = ~clk_in;

  // Advance one cycle; outputs are sampled 1 time unit after the edge
  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  task automatic drive(input logic de, input logic [7:0] d0, input logic [7:0] d1,
                       input logic [7:0] d2, input logic [1:0] c0, input logic [1:0] c1,
                       input logic [1:0] c2);
    de_in   = de;
    data_in = {d2, d1, d0};
    ctrl_in = {c2, c1, c0};
  endtask

  function automatic logic [9:0] sym_of(input int ch);
    return tmds_out[10*ch +: 10];
  endfunction

  function automatic logic [9:0] tok(input logic [1:0] c);
    case (c)
      2'b00:   return 10'h354;
      2'b01:   return 10'h0AB;
      2'b10:   return 10'h154;
      default: return 10'h2AB;
    endcase
  endfunction

  // Reference encoder written from the TMDS algorithm with integer arithmetic
  task automatic model_enc(input logic [7:0] d, input int cnt_in,
                           output logic [9:0] sym, output int cnt_out);
    int n1d, n1, n0;
    logic use_xnor, qm8;
    logic [7:0] q;
    n1d = $countones(d);
    use_xnor = (n1d > 4) || (n1d == 4 && d[0] == 1'b0);
    q[0] = d[0];
    for (int k = 1; k < 8; k++) q[k] = use_xnor ? !(q[k-1] ^ d[k]) : (q[k-1] ^ d[k]);
    qm8 = !use_xnor;
    n1 = $countones(q);
    n0 = 8 - n1;
    if (cnt_in == 0 || n1 == n0) begin
      sym = {!qm8, qm8, qm8 ? q : ~q};
      cnt_out = cnt_in + (qm8 ? (n1 - n0) : (n0 - n1));
    end else if ((cnt_in > 0 && n1 > n0) || (cnt_in < 0 && n0 > n1)) begin
      sym = {1'b1, qm8, ~q};
      cnt_out = cnt_in + (qm8 ? 2 : 0) + (n0 - n1);
    end else begin
      sym = {1'b0, qm8, q};
      cnt_out = cnt_in - (qm8 ? 0 : 2) + (n1 - n0);
    end
  endtask

  task automatic test_reset();
    rst_in = 1'b1;
    for (int i = 0; i < 3; i++) begin
      drive($urandom_range(0, 1), 8'($urandom), 8'($urandom), 8'($urandom),
            2'($urandom), 2'($urandom), 2'($urandom));
      tick();
      checks++;
      if (tmds_out !== 30'd0) begin
        errors++;
        $display("FAIL reset_tmds cyc%0d: got %h expected 0", i, tmds_out);
      end
      checks++;
      if (de_out !== 1'b0) begin
        errors++;
        $display("FAIL reset_de cyc%0d: got %b expected 0", i, de_out);
      end
    end
    rst_in = 1'b0;
    drive(1'b0, 8'($urandom), 8'($urandom), 8'($urandom), 2'b00, 2'b00, 2'b00);
    for (int c = 1; c <= 2; c++) begin
      tick();
      for (int ch = 0; ch < 3; ch++) begin
        checks++;
        if (sym_of(ch) !== 10'h354) begin
          errors++;
          $display("FAIL reset_release r+%0d ch%0d: got %h expected 354", c, ch, sym_of(ch));
        end
      end
      checks++;
      if (de_out !== 1'b0) begin
        errors++;
        $display("FAIL reset_release_de r+%0d: got %b expected 0", c, de_out);
      end
    end
  endtask

  task automatic test_control_tokens();
    logic [1:0] cv[5][3];
    for (int j = 0; j < 4; j++) begin
      cv[j][0] = 2'(j % 4);
      cv[j][1] = 2'((j + 1) % 4);
      cv[j][2] = 2'((j + 2) % 4);
    end
    cv[4][0] = 2'b01;
    cv[4][1] = 2'b00;
    cv[4][2] = 2'b11;
    for (int i = 0; i <= 5; i++) begin
      if (i < 5) drive(1'b0, 8'($urandom), 8'($urandom), 8'($urandom), cv[i][0], cv[i][1], cv[i][2]);
      tick();
      if (i >= 1) begin
        for (int ch = 0; ch < 3; ch++) begin
          checks++;
          if (sym_of(ch) !== tok(cv[i-1][ch])) begin
            errors++;
            $display("FAIL ctrl_token vec%0d ch%0d: got %h expected %h",
                     i - 1, ch, sym_of(ch), tok(cv[i-1][ch]));
          end
        end
        checks++;
        if (de_out !== 1'b0) begin
          errors++;
          $display("FAIL ctrl_de vec%0d: got %b expected 0", i - 1, de_out);
        end
      end
    end
  endtask

  task automatic test_disparity_run();
    logic [9:0] exp_s[4];
    exp_s = '{10'h100, 10'h3FF, 10'h100, 10'h3FF};
    drive(1'b0, 8'h00, 8'h00, 8'h00, 2'b00, 2'b00, 2'b00);
    tick();
    for (int i = 0; i <= 4; i++) begin
      if (i < 4) drive(1'b1, 8'h00, 8'h00, 8'h00, 2'b00, 2'b00, 2'b00);
      else       drive(1'b0, 8'h00, 8'h00, 8'h00, 2'b00, 2'b00, 2'b00);
      tick();
      if (i >= 1) begin
        for (int ch = 0; ch < 3; ch++) begin
          checks++;
          if (sym_of(ch) !== exp_s[i-1]) begin
            errors++;
            $display("FAIL disparity_run sym%0d ch%0d: got %h expected %h",
                     i - 1, ch, sym_of(ch), exp_s[i-1]);
          end
        end
        checks++;
        if (de_out !== 1'b1) begin
          errors++;
          $display("FAIL disparity_run_de sym%0d: got %b expected 1", i - 1, de_out);
        end
      end
    end
  endtask

  task automatic test_xnor_path();
    logic       dev[4];
    logic [7:0] dv[4];
    logic [9:0] exp_s[4];
    dev   = '{1'b1, 1'b1, 1'b0, 1'b1};
    dv    = '{8'hFF, 8'h0F, 8'h00, 8'h0F};
    exp_s = '{10'h200, 10'h3FA, 10'h354, 10'h105};
    drive(1'b0, 8'h00, 8'h00, 8'h00, 2'b00, 2'b00, 2'b00);
    tick();
    for (int i = 0; i <= 4; i++) begin
      if (i < 4) drive(dev[i], dv[i], dv[i], dv[i], 2'b00, 2'b00, 2'b00);
      else       drive(1'b0, 8'h00, 8'h00, 8'h00, 2'b00, 2'b00, 2'b00);
      tick();
      if (i >= 1) begin
        for (int ch = 0; ch < 3; ch++) begin
          checks++;
          if (sym_of(ch) !== exp_s[i-1]) begin
            errors++;
            $display("FAIL xnor_path sym%0d ch%0d: got %h expected %h",
                     i - 1, ch, sym_of(ch), exp_s[i-1]);
          end
        end
        checks++;
        if (de_out !== dev[i-1]) begin
          errors++;
          $display("FAIL xnor_path_de sym%0d: got %b expected %b", i - 1, de_out, dev[i-1]);
        end
      end
    end
  endtask

  task automatic test_channel_independence();
    logic [7:0] dv[3];
    logic [9:0] exp_s[16][3];
    int         mcnt[3];
    int         disp[3];
    dv = '{8'h00, 8'hFF, 8'h55};
    for (int ch = 0; ch < 3; ch++) begin
      mcnt[ch] = 0;
      disp[ch] = 0;
    end
    for (int i = 0; i < 16; i++) begin
      for (int ch = 0; ch < 3; ch++) begin
        int nc;
        model_enc(dv[ch], mcnt[ch], exp_s[i][ch], nc);
        mcnt[ch] = nc;
      end
    end
    drive(1'b0, 8'h00, 8'h00, 8'h00, 2'b00, 2'b00, 2'b00);
    tick();
    for (int i = 0; i <= 16; i++) begin
      if (i < 16) drive(1'b1, dv[0], dv[1], dv[2], 2'b00, 2'b00, 2'b00);
      else        drive(1'b0, 8'h00, 8'h00, 8'h00, 2'b00, 2'b00, 2'b00);
      tick();
      if (i >= 1) begin
        for (int ch = 0; ch < 3; ch++) begin
          checks++;
          if (sym_of(ch) !== exp_s[i-1][ch]) begin
            errors++;
            $display("FAIL independence sym%0d ch%0d: got %h expected %h",
                     i - 1, ch, sym_of(ch), exp_s[i-1][ch]);
          end
          disp[ch] = disp[ch] + 2 * $countones(sym_of(ch)) - 10;
          checks++;
          if (disp[ch] > 10 || disp[ch] < -10) begin
            errors++;
            $display("FAIL disparity_bound sym%0d ch%0d: got %0d expected within -10..10",
                     i - 1, ch, disp[ch]);
          end
        end
      end
    end
  endtask

  task automatic test_reset_mid_frame();
    logic [9:0] exp_s[3];
    exp_s = '{10'h100, 10'h200, 10'h133};
    drive(1'b0, 8'h00, 8'h00, 8'h00, 2'b00, 2'b00, 2'b00);
    tick();
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 8'h00, 8'h00, 8'h00, 2'b00, 2'b00, 2'b00);
      tick();
    end
    rst_in = 1'b1;
    tick();
    checks++;
    if (tmds_out !== 30'd0 || de_out !== 1'b0) begin
      errors++;
      $display("FAIL midframe_reset: got tmds %h de %b expected 0 0", tmds_out, de_out);
    end
    rst_in = 1'b0;
    drive(1'b1, 8'h00, 8'hFF, 8'h55, 2'b00, 2'b00, 2'b00);
    tick();
    for (int ch = 0; ch < 3; ch++) begin
      checks++;
      if (sym_of(ch) !== 10'h354) begin
        errors++;
        $display("FAIL midframe_r1 ch%0d: got %h expected 354", ch, sym_of(ch));
      end
    end
    tick();
    for (int ch = 0; ch < 3; ch++) begin
      checks++;
      if (sym_of(ch) !== exp_s[ch]) begin
        errors++;
        $display("FAIL midframe_r2 ch%0d: got %h expected %h", ch, sym_of(ch), exp_s[ch]);
      end
    end
    checks++;
    if (de_out !== 1'b1) begin
      errors++;
      $display("FAIL midframe_r2_de: got %b expected 1", de_out);
    end
  endtask

  task automatic test_de_toggle();
    logic [9:0] vid[3];
    logic [9:0] ctl[3];
    vid = '{10'h100, 10'h200, 10'h133};
    ctl = '{10'h0AB, 10'h154, 10'h2AB};
    drive(1'b0, 8'h00, 8'h00, 8'h00, 2'b00, 2'b00, 2'b00);
    tick();
    for (int i = 0; i <= 8; i++) begin
      if (i < 8) drive((i % 2) == 0, 8'h00, 8'hFF, 8'h55, 2'b01, 2'b10, 2'b11);
      else       drive(1'b0, 8'h00, 8'h00, 8'h00, 2'b00, 2'b00, 2'b00);
      tick();
      if (i >= 1) begin
        for (int ch = 0; ch < 3; ch++) begin
          logic [9:0] e;
          e = (((i - 1) % 2) == 0) ? vid[ch] : ctl[ch];
          checks++;
          if (sym_of(ch) !== e) begin
            errors++;
            $display("FAIL de_toggle sym%0d ch%0d: got %h expected %h", i - 1, ch, sym_of(ch), e);
          end
        end
        checks++;
        if (de_out !== (((i - 1) % 2) == 0)) begin
          errors++;
          $display("FAIL de_toggle_de sym%0d: got %b expected %b", i - 1, de_out, ((i - 1) % 2) == 0);
        end
      end
    end
  endtask

  initial begin
    checks  = 0;
    errors  = 0;
    rst_in  = 1'b1;
    de_in   = 1'b0;
    data_in = 24'd0;
    ctrl_in = 6'd0;
    test_reset();
    test_control_tokens();
    test_disparity_run();
    test_xnor_path();
    test_channel_independence();
    test_reset_mid_frame();
    test_de_toggle();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
